// File: rtl/queue_pkg.sv
// queue_pkg
//   Shared helper for the queue controller slice.
//   level_w(aw) : width of the occupancy count for a RAM of 2^aw words.
//                 The count reaches 2^aw + 2 (RAM full, one read in flight
//                 or captured, two output-buffer entries), so aw+2 bits.
package queue_pkg;

    function automatic int level_w(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/queue_obuf.sv
// queue_obuf
//   Two-entry show-ahead output buffer. Entry 0 is always the head and is
//   driven straight from a flop, so the head word is registered.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     cap         : append cap_data at this edge (RAM read data is valid)
//     cap_data    : word to append
//     pop         : remove the head at this edge (caller only asserts it
//                   while valid is high)
//     head        : current head word
//     valid       : buffer holds at least one word
//     cnt         : number of words held, 0..2
//   The caller never captures into a full buffer unless it pops in the
//   same cycle.
module queue_obuf
    import queue_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;

    assign head  = e0;
    assign valid = (cnt != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            case ({cap, pop})
                2'b10: begin
                    if (cnt == 2'd0) e0 <= cap_data;
                    else             e1 <= cap_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    e0  <= e1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged; the new word goes behind whatever
                    // survives the pop so FIFO order holds.
                    if (cnt == 2'd1) begin
                        e0 <= cap_data;
                    end else begin
                        e0 <= e1;
                        e1 <= cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/queue_ctrl.sv
// queue_ctrl
//   FIFO controller that runs an external simple-dual-port RAM (1-cycle
//   read latency) as a circular buffer, with a 2-entry show-ahead output
//   buffer and sticky overflow/underflow flags.
//   Ports:
//     clk, rst_n           : clock, asynchronous active-low reset
//     push, in_data        : enqueue in_data (dropped and ovf_err set if full)
//     pop                  : consume out_data (ignored, udf_err set, if !out_valid)
//     out_data, out_valid  : registered head word and its valid
//     full                 : all 2^AW RAM words occupied
//     level                : total words held (RAM + read in flight + obuf)
//     ovf_err, udf_err     : sticky error flags, cleared by err_clr
//     ram_we/waddr/wdata   : RAM write port
//     ram_re/raddr, rdata  : RAM read port, rdata valid the cycle after ram_re
//
//   Handshake: a push is accepted in any cycle where full is low, a pop is
//   accepted in any cycle where out_valid is high; both take effect at the
//   rising edge. push while full and pop while !out_valid are not stalls,
//   they are errors recorded in the sticky flags.
module queue_ctrl
    import queue_pkg::*;
#(
    parameter int AW    = 10,
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    output logic                    full,
    output logic [level_w(AW)-1:0]  level,
    output logic                    ovf_err,
    output logic                    udf_err,
    input  logic                    err_clr,
    output logic                    ram_we,
    output logic [AW-1:0]           ram_waddr,
    output logic [WIDTH-1:0]        ram_wdata,
    output logic                    ram_re,
    output logic [AW-1:0]           ram_raddr,
    input  logic [WIDTH-1:0]        ram_rdata
);

    localparam int LW = level_w(AW);
    localparam logic [AW:0] CAPACITY = (AW+1)'(1) << AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic          rd_pend;
    logic [1:0]    obuf_cnt;
    logic          pop_ok;
    logic [2:0]    committed;

    assign pop_ok = pop && out_valid;

    assign full      = (ram_cnt == CAPACITY);
    assign level     = LW'(ram_cnt) + LW'(rd_pend) + LW'(obuf_cnt);

    assign ram_we    = push && !full;
    assign ram_waddr = wr_ptr;
    assign ram_wdata = in_data;
    assign ram_raddr = rd_ptr;

    // Words already owned by the output side after this edge must not
    // exceed the buffer's two slots. Only words counted in ram_cnt before
    // this edge are eligible, so the read never hits the address being
    // written in the same cycle.
    assign committed = {1'b0, obuf_cnt} + {2'b0, rd_pend};
    assign ram_re    = (ram_cnt != '0) && (committed < (3'd2 + {2'b0, pop_ok}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (ram_we) wr_ptr <= wr_ptr + AW'(1);
            if (ram_re) rd_ptr <= rd_ptr + AW'(1);
            case ({ram_we, ram_re})
                2'b10:   ram_cnt <= ram_cnt + (AW+1)'(1);
                2'b01:   ram_cnt <= ram_cnt - (AW+1)'(1);
                default: ;
            endcase
            rd_pend <= ram_re;
            // A new error in the clearing cycle keeps the flag set.
            ovf_err <= (ovf_err && !err_clr) || (push && full);
            udf_err <= (udf_err && !err_clr) || (pop && !out_valid);
        end
    end

    queue_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap      (rd_pend),
        .cap_data (ram_rdata),
        .pop      (pop_ok),
        .head     (out_data),
        .valid    (out_valid),
        .cnt      (obuf_cnt)
    );

endmodule

// File: tb/tb_queue_ctrl.sv
// tb_queue_ctrl
//   Bench for queue_ctrl at AW=2 with a behavioural 1-cycle RAM. The
//   reference is a word queue; each word remembers the edge it was pushed
//   at, and the head is expected visible once two edges have passed since
//   its push.
module tb_queue_ctrl;

    localparam int AW    = 2;
    localparam int WIDTH = 32;
    localparam int LW    = AW + 2;
    localparam int MAXW  = (1 << AW) + 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             push = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             full;
    logic [LW-1:0]    level;
    logic             ovf_err;
    logic             udf_err;
    logic             err_clr = 1'b0;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_rdata = '0;

    logic [WIDTH-1:0] mem [1<<AW];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               exp_t[$];
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;

    // ---------------- clock / reset / RAM ----------------
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    queue_ctrl #(
        .AW    (AW),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .in_data   (in_data),
        .pop       (pop),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (full),
        .level     (level),
        .ovf_err   (ovf_err),
        .udf_err   (udf_err),
        .err_clr   (err_clr),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_valid();
        return (exp_q.size() > 0) && (cyc - exp_t[0] >= 2);
    endfunction

    task automatic check_state();
        check("level", 64'(level), 64'(exp_q.size()));
        check("out_valid", 64'(out_valid), 64'(exp_valid()));
        if (exp_valid()) check("out_data", 64'(out_data), 64'(exp_q[0]));
        check("ovf_err", 64'(ovf_err), 64'(m_ovf));
        check("udf_err", 64'(udf_err), 64'(m_udf));
    endtask

    // ---------------- driver ----------------
    // A push is taken as accepted whenever fewer than MAXW words are held;
    // the stimulus only pushes into a partly filled queue from an empty
    // start or keeps the level low enough that the RAM cannot be full.
    task automatic step(input bit pu, input logic [WIDTH-1:0] d, input bit po, input bit clr);
        bit v;
        bit acc;
        push    = pu;
        in_data = d;
        pop     = po;
        err_clr = clr;
        v   = exp_valid();
        acc = pu && (exp_q.size() < MAXW);
        @(posedge clk);
        #1;
        cyc++;
        if (po && v) begin
            void'(exp_q.pop_front());
            void'(exp_t.pop_front());
        end
        if (acc) begin
            exp_q.push_back(d);
            exp_t.push_back(cyc);
        end
        m_ovf = (m_ovf && !clr) || (pu && !acc);
        m_udf = (m_udf && !clr) || (po && !v);
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        check_state();
    endtask

    task automatic apply_reset();
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst level", 64'(level), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_data", 64'(out_data), 64'd0);
        check("rst full", 64'(full), 64'd0);
        check("rst ovf_err", 64'(ovf_err), 64'd0);
        check("rst udf_err", 64'(udf_err), 64'd0);
        check("rst ram_we", 64'(ram_we), 64'd0);
        check("rst ram_re", 64'(ram_re), 64'd0);
        exp_q.delete();
        exp_t.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        apply_reset();

        // Three pushes, then drain in order.
        step(1'b1, 32'h11, 1'b0, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b0, 1'b0);
        check("A out_data", 64'(out_data), 64'h11);
        check("A level", 64'(level), 64'd3);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("A drained", 64'(out_valid), 64'd0);

        // Fill to the maximum, then overflow.
        for (int i = 0; i < 6; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        check("B full", 64'(full), 64'd1);
        check("B level6", 64'(level), 64'd6);
        push = 1'b1;
        in_data = 32'h6;
        #1;
        check("B ram_we blocked", 64'(ram_we), 64'd0);
        step(1'b1, 32'h6, 1'b0, 1'b0);
        check("B ovf", 64'(ovf_err), 64'd1);
        for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
        check("B empty", 64'(level), 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Underflow on empty, then clear.
        apply_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        check("C udf", 64'(udf_err), 64'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        check("C udf clr", 64'(udf_err), 64'd0);

        // Streaming: prime three words, then push+pop every cycle.
        step(1'b1, 32'd100, 1'b0, 1'b0);
        step(1'b1, 32'd101, 1'b0, 1'b0);
        step(1'b1, 32'd102, 1'b0, 1'b0);
        step(1'b0, 32'd0,   1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'(103 + i), 1'b1, 1'b0);
            check("D no bubble", 64'(out_valid), 64'd1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            bit pu;
            bit po;
            bit clr;
            pu  = ($urandom_range(0, 1) == 1) && (exp_q.size() < 4);
            po  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 15) == 0);
            step(pu, $urandom, po, clr);
        end

        // Reset while holding five words.
        apply_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'(200 + i), 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("F level5", 64'(level), 64'd5);
        apply_reset();
        step(1'b1, 32'hAB, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("F fresh word", 64'(out_data), 64'hAB);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        check("F no stale", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
